// File: rtl/roce_stack_req_xlate_mc.sv
// Multi-channel RDMA request translator. It picks request channels round-robin,
// translates the virtual address through the shared PD table, checks the key,
// access rights and bounds, and then emits DataMover commands. Each command
// stays within MAX_BTT bytes and does not cross a 2^BOUND_LOG2 boundary.
module roce_stack_req_xlate_mc #(
  parameter int NCH        = 2,
  parameter int LEN_W      = 32,
  parameter int MAX_BTT    = 8388607,
  parameter int BOUND_LOG2 = 12,
  parameter bit READ       = 1'b1,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_i,
  input  logic                  aresetn_i,
  input  logic [NCH-1:0]        req_valid_i,
  output logic [NCH-1:0]        req_ready_o,
  input  logic [NCH*64-1:0]     req_vaddr_i,
  input  logic [NCH*LEN_W-1:0]  req_len_i,
  input  logic [NCH*32-1:0]     req_key_i,
  input  logic [NCH*16-1:0]     req_qpn_i,
  input  logic [NCH-1:0]        req_last_i,
  input  logic [NCH-1:0]        req_local_i,
  output logic                  xl_req_valid_o,
  input  logic                  xl_req_ready_i,
  output logic [63:0]           xl_req_vaddr_o,
  output logic [23:0]           xl_req_pdidx_o,
  output logic [15:0]           xl_req_qpn_o,
  input  logic                  xl_resp_valid_i,
  output logic                  xl_resp_ready_o,
  input  logic [63:0]           xl_resp_paddr_i,
  input  logic [63:0]           xl_resp_base_vaddr_i,
  input  logic [47:0]           xl_resp_buflen_i,
  input  logic [3:0]            xl_resp_access_i,
  input  logic [31:0]           xl_resp_rkey_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [103:0]          cmd_data_o,
  output logic [CH_W-1:0]       cmd_chan_o,
  output logic [NCH-1:0]        err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_XREQ  = 3'd1;
  localparam logic [2:0] S_XRESP = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_SPLIT = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  // Per-channel views of the flattened request buses.
  logic [63:0]    ch_vaddr [NCH];
  logic [LEN_W-1:0] ch_len [NCH];
  logic [31:0]    ch_key   [NCH];
  logic [15:0]    ch_qpn   [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign ch_vaddr[gi] = req_vaddr_i[gi*64 +: 64];
    assign ch_len[gi]   = req_len_i[gi*LEN_W +: LEN_W];
    assign ch_key[gi]   = req_key_i[gi*32 +: 32];
    assign ch_qpn[gi]   = req_qpn_i[gi*16 +: 16];
  end

  // Only rkey[8:0] takes part in the key check.
  logic unused_rkey_bits;
  assign unused_rkey_bits = ^xl_resp_rkey_i[31:9];

  logic [2:0]       state_reg;
  logic [CH_W-1:0]  rr_ptr_reg, gnt_reg;
  logic [63:0]      vaddr_reg, paddr_reg;
  logic [LEN_W-1:0] len_reg, rem_reg, chunk_reg;
  logic [31:0]      key_reg;
  logic [15:0]      qpn_reg;
  logic             last_reg;
  logic [47:0]      buflen_reg, acc_reg;
  logic [3:0]       access_reg;
  logic [8:0]       rkey_reg;
  logic [NCH-1:0]   err_reg;
  logic             cmd_valid_reg;
  logic [103:0]     cmd_data_reg;
  logic [CH_W-1:0]  cmd_chan_reg;

  // Per-channel translation context, so that later packets of a message skip the PD lookup.
  logic [NCH-1:0]   ctx_valid_reg;
  logic [63:0]      ctx_paddr_reg  [NCH];
  logic [47:0]      ctx_buflen_reg [NCH];
  logic [47:0]      ctx_acc_reg    [NCH];
  logic [3:0]       ctx_access_reg [NCH];
  logic [8:0]       ctx_rkey_reg   [NCH];

  // Round-robin search for the first valid channel, starting at rr_ptr.
  logic            arb_found;
  logic [CH_W-1:0] arb_gnt;
  always_comb begin
    arb_found = 1'b0;
    arb_gnt   = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [CH_W-1:0] cand;
      cand = CH_W'((int'(rr_ptr_reg) + i) % NCH);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_gnt   = cand;
      end
    end
  end

  // The request ready is a single-cycle pulse to the granted channel while the FSM is idle.
  always_comb begin
    req_ready_o = '0;
    if (aresetn_i && state_reg == S_IDLE && arb_found)
      req_ready_o[arb_gnt] = 1'b1;
  end

  // Checks for key, bounds (no wrap), access rights and zero length.
  logic [63:0] xl_offset;
  logic [48:0] bound_sum;
  logic        access_ok, check_err;
  always_comb begin
    xl_offset = vaddr_reg - xl_resp_base_vaddr_i;
    bound_sum = {1'b0, acc_reg} + 49'(len_reg);
    if (READ) access_ok = (access_reg == 4'b0010) || (access_reg == 4'b0000);
    else      access_ok = (access_reg == 4'b0010) || (access_reg == 4'b0001);
    check_err = (key_reg[7:0] != rkey_reg[7:0]) || rkey_reg[8] ||
                (bound_sum > {1'b0, buflen_reg}) || !access_ok || (len_reg == '0);
  end

  // Size of the next command: limited by the bytes remaining, MAX_BTT and the distance to the next boundary.
  logic [63:0] room_w, chunk_w;
  logic        eof_w;
  always_comb begin
    room_w  = (64'd1 << BOUND_LOG2) - 64'(paddr_reg[BOUND_LOG2-1:0]);
    chunk_w = 64'(rem_reg);
    if (chunk_w > 64'(MAX_BTT)) chunk_w = 64'(MAX_BTT);
    if (chunk_w > room_w)       chunk_w = room_w;
    eof_w = (chunk_w == 64'(rem_reg));
  end

  // Main request FSM together with the per-channel context updates.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= '0;
      gnt_reg       <= '0;
      vaddr_reg     <= '0;
      paddr_reg     <= '0;
      len_reg       <= '0;
      rem_reg       <= '0;
      chunk_reg     <= '0;
      key_reg       <= '0;
      qpn_reg       <= '0;
      last_reg      <= 1'b0;
      buflen_reg    <= '0;
      acc_reg       <= '0;
      access_reg    <= '0;
      rkey_reg      <= '0;
      err_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_data_reg  <= '0;
      cmd_chan_reg  <= '0;
      ctx_valid_reg <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx_paddr_reg[i]  <= '0;
        ctx_buflen_reg[i] <= '0;
        ctx_acc_reg[i]    <= '0;
        ctx_access_reg[i] <= '0;
        ctx_rkey_reg[i]   <= '0;
      end
    end else begin
      err_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (arb_found) begin
            gnt_reg    <= arb_gnt;
            rr_ptr_reg <= (arb_gnt == CH_W'(NCH-1)) ? '0 : arb_gnt + 1'b1;
            vaddr_reg  <= ch_vaddr[arb_gnt];
            len_reg    <= ch_len[arb_gnt];
            key_reg    <= ch_key[arb_gnt];
            qpn_reg    <= ch_qpn[arb_gnt];
            last_reg   <= req_last_i[arb_gnt];
            if (req_local_i[arb_gnt]) begin
              paddr_reg <= ch_vaddr[arb_gnt];
              rem_reg   <= ch_len[arb_gnt];
              state_reg <= S_SPLIT;
            end else if (ctx_valid_reg[arb_gnt]) begin
              paddr_reg  <= ctx_paddr_reg[arb_gnt];
              buflen_reg <= ctx_buflen_reg[arb_gnt];
              acc_reg    <= ctx_acc_reg[arb_gnt];
              access_reg <= ctx_access_reg[arb_gnt];
              rkey_reg   <= ctx_rkey_reg[arb_gnt];
              state_reg  <= S_CHECK;
            end else begin
              state_reg <= S_XREQ;
            end
          end
        end
        S_XREQ: if (xl_req_ready_i) state_reg <= S_XRESP;
        S_XRESP: begin
          if (xl_resp_valid_i) begin
            paddr_reg  <= xl_resp_paddr_i + xl_offset;
            acc_reg    <= xl_offset[47:0];
            buflen_reg <= xl_resp_buflen_i;
            access_reg <= xl_resp_access_i;
            rkey_reg   <= xl_resp_rkey_i[8:0];
            state_reg  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (check_err) begin
            err_reg[gnt_reg]       <= 1'b1;
            ctx_valid_reg[gnt_reg] <= 1'b0;
            state_reg              <= S_IDLE;
          end else begin
            ctx_paddr_reg[gnt_reg]  <= paddr_reg + 64'(len_reg);
            ctx_buflen_reg[gnt_reg] <= buflen_reg;
            ctx_acc_reg[gnt_reg]    <= acc_reg + 48'(len_reg);
            ctx_access_reg[gnt_reg] <= access_reg;
            ctx_rkey_reg[gnt_reg]   <= rkey_reg;
            ctx_valid_reg[gnt_reg]  <= !last_reg;
            rem_reg                 <= len_reg;
            state_reg               <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          chunk_reg     <= chunk_w[LEN_W-1:0];
          cmd_data_reg  <= {8'b0, paddr_reg, 1'b0, eof_w, 6'b0, 1'b1, chunk_w[22:0]};
          cmd_chan_reg  <= gnt_reg;
          cmd_valid_reg <= 1'b1;
          state_reg     <= S_SEND;
        end
        S_SEND: begin
          if (cmd_ready_i) begin
            cmd_valid_reg <= 1'b0;
            paddr_reg     <= paddr_reg + 64'(chunk_reg);
            rem_reg       <= rem_reg - chunk_reg;
            state_reg     <= (rem_reg == chunk_reg) ? S_IDLE : S_SPLIT;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign xl_req_valid_o  = (state_reg == S_XREQ);
  assign xl_resp_ready_o = (state_reg == S_XRESP);
  assign xl_req_vaddr_o  = vaddr_reg;
  assign xl_req_pdidx_o  = key_reg[31:8];
  assign xl_req_qpn_o    = qpn_reg;
  assign cmd_valid_o     = cmd_valid_reg;
  assign cmd_data_o      = cmd_data_reg;
  assign cmd_chan_o      = cmd_chan_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_roce_stack_req_xlate_mc.sv
// Directed testbench for roce_stack_req_xlate_mc (NCH=2, read side).
module tb_roce_stack_req_xlate_mc;
  localparam int NCH = 2;
  localparam int LEN_W = 32;
  localparam int CH_W = 1;

  logic clk_i = 1'b0;
  logic aresetn_i;
  logic [NCH-1:0] req_valid_i, req_ready_o, req_last_i, req_local_i;
  logic [NCH*64-1:0] req_vaddr_i;
  logic [NCH*LEN_W-1:0] req_len_i;
  logic [NCH*32-1:0] req_key_i;
  logic [NCH*16-1:0] req_qpn_i;
  logic xl_req_valid_o, xl_req_ready_i;
  logic [63:0] xl_req_vaddr_o;
  logic [23:0] xl_req_pdidx_o;
  logic [15:0] xl_req_qpn_o;
  logic xl_resp_valid_i, xl_resp_ready_o;
  logic [63:0] xl_resp_paddr_i, xl_resp_base_vaddr_i;
  logic [47:0] xl_resp_buflen_i;
  logic [3:0] xl_resp_access_i;
  logic [31:0] xl_resp_rkey_i;
  logic cmd_valid_o, cmd_ready_i;
  logic [103:0] cmd_data_o;
  logic [CH_W-1:0] cmd_chan_o;
  logic [NCH-1:0] err_o;

  roce_stack_req_xlate_mc #(.NCH(NCH), .LEN_W(LEN_W), .MAX_BTT(8388607), .BOUND_LOG2(12), .READ(1'b1)) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
    .req_len_i(req_len_i), .req_key_i(req_key_i), .req_qpn_i(req_qpn_i),
    .req_last_i(req_last_i), .req_local_i(req_local_i),
    .xl_req_valid_o(xl_req_valid_o), .xl_req_ready_i(xl_req_ready_i),
    .xl_req_vaddr_o(xl_req_vaddr_o), .xl_req_pdidx_o(xl_req_pdidx_o), .xl_req_qpn_o(xl_req_qpn_o),
    .xl_resp_valid_i(xl_resp_valid_i), .xl_resp_ready_o(xl_resp_ready_o),
    .xl_resp_paddr_i(xl_resp_paddr_i), .xl_resp_base_vaddr_i(xl_resp_base_vaddr_i),
    .xl_resp_buflen_i(xl_resp_buflen_i), .xl_resp_access_i(xl_resp_access_i),
    .xl_resp_rkey_i(xl_resp_rkey_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_data_o(cmd_data_o),
    .cmd_chan_o(cmd_chan_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_fail = 0;
  int xl_cnt = 0;
  logic [63:0] xl_vaddr_last;
  logic [23:0] xl_pd_last;
  logic [15:0] xl_qpn_last;
  logic [103:0] cmd_q[$];
  int chan_q[$];
  int gnt_q[$];
  int err_cyc[NCH];

  // Monitor: samples handshakes and pulses on the falling edge.
  initial begin
    for (int c = 0; c < NCH; c++) err_cyc[c] = 0;
    forever begin
      @(negedge clk_i);
      if (xl_req_valid_o && xl_req_ready_i) begin
        xl_cnt++;
        xl_vaddr_last = xl_req_vaddr_o;
        xl_pd_last = xl_req_pdidx_o;
        xl_qpn_last = xl_req_qpn_o;
      end
      if (cmd_valid_o && cmd_ready_i) begin
        cmd_q.push_back(cmd_data_o);
        chan_q.push_back(int'(cmd_chan_o));
      end
      for (int c = 0; c < NCH; c++) begin
        if (req_valid_i[c] && req_ready_o[c]) gnt_q.push_back(c);
        if (err_o[c]) err_cyc[c]++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [103:0] mk_cmd(input logic [63:0] pa, input logic [22:0] btt, input logic eof);
    return {8'b0, pa, 1'b0, eof, 6'b0, 1'b1, btt};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_resp(input logic [63:0] pa, input logic [63:0] base, input logic [47:0] blen,
                          input logic [3:0] acc, input logic [31:0] rkey);
    xl_resp_paddr_i = pa; xl_resp_base_vaddr_i = base; xl_resp_buflen_i = blen;
    xl_resp_access_i = acc; xl_resp_rkey_i = rkey;
  endtask

  task automatic set_ch(input int ch, input logic [63:0] va, input logic [31:0] len, input logic [31:0] key,
                        input logic [15:0] qpn, input logic last, input logic loc);
    req_vaddr_i[ch*64 +: 64] = va;
    req_len_i[ch*LEN_W +: LEN_W] = len;
    req_key_i[ch*32 +: 32] = key;
    req_qpn_i[ch*16 +: 16] = qpn;
    req_last_i[ch] = last;
    req_local_i[ch] = loc;
  endtask

  task automatic send_req(input int ch, input logic [63:0] va, input logic [31:0] len, input logic [31:0] key,
                          input logic [15:0] qpn, input logic last, input logic loc);
    bit got = 1'b0;
    step(1);
    set_ch(ch, va, len, key, qpn, last, loc);
    req_valid_i[ch] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      if (req_ready_o[ch]) got = 1'b1;
    end
    step(1);
    req_valid_i[ch] = 1'b0;
    n_vec++;
    if (!got) begin
      n_fail++;
      $display("FAIL req_accept ch%0d: ready seen=%0d required=1", ch, got);
    end
    $display("req ch%0d vaddr=%h len=%0d last=%0d local=%0d", ch, va, len, last, loc);
  endtask

  task automatic clear_q();
    cmd_q.delete(); chan_q.delete(); gnt_q.delete();
  endtask

  task automatic chk_cmd(input string name, input int idx, input logic [103:0] exp, input int exp_ch);
    n_vec++;
    if (cmd_q.size() <= idx) begin
      n_fail++;
      $display("FAIL %s: cmd %0d missing (got %0d cmds)", name, idx, cmd_q.size());
    end else if (cmd_q[idx] !== exp || chan_q[idx] != exp_ch) begin
      n_fail++;
      $display("FAIL %s: cmd=%h chan=%0d required cmd=%h chan=%0d", name, cmd_q[idx], chan_q[idx], exp, exp_ch);
    end else begin
      $display("cmd %s ok: %h chan=%0d", name, cmd_q[idx], chan_q[idx]);
    end
  endtask

  task automatic test_reset();
    aresetn_i = 1'b0;
    req_valid_i = '1; req_vaddr_i = '0; req_len_i = '0; req_key_i = '0; req_qpn_i = '0;
    req_last_i = '0; req_local_i = '0;
    xl_req_ready_i = 1'b1; xl_resp_valid_i = 1'b1; cmd_ready_i = 1'b1;
    set_resp(64'h0, 64'h0, 48'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({req_ready_o, cmd_valid_o, cmd_data_o, cmd_chan_o, err_o, xl_req_valid_o, xl_resp_ready_o,
         xl_req_vaddr_o, xl_req_pdidx_o, xl_req_qpn_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b cmd_valid=%b cmd=%h err=%b xlv=%b required all 0",
               req_ready_o, cmd_valid_o, cmd_data_o, err_o, xl_req_valid_o);
    end
    req_valid_i = '0;
    step(1);
    aresetn_i = 1'b1;
    step(2);
    $display("reset checked");
  endtask

  task automatic test_single();
    int x0 = xl_cnt;
    clear_q();
    set_resp(64'h8000_0000, 64'h1000, 48'd4096, 4'b0010, 32'h05);
    send_req(0, 64'h1000, 256, 32'h0000_0105, 16'h0011, 1'b1, 1'b0);
    step(30);
    n_vec++;
    if (xl_cnt - x0 != 1 || xl_vaddr_last !== 64'h1000 || xl_pd_last !== 24'h1 || xl_qpn_last !== 16'h11) begin
      n_fail++;
      $display("FAIL single_xlreq: n=%0d vaddr=%h pd=%h qpn=%h required n=1 vaddr=1000 pd=1 qpn=11",
               xl_cnt - x0, xl_vaddr_last, xl_pd_last, xl_qpn_last);
    end
    n_vec++;
    if (cmd_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_count: cmds=%0d required 1", cmd_q.size());
    end
    chk_cmd("single", 0, mk_cmd(64'h8000_0000, 23'd256, 1'b1), 0);
  endtask

  task automatic test_split();
    int x0 = xl_cnt;
    clear_q();
    set_resp(64'h8000_0000, 64'h1000, 48'h2000, 4'b0010, 32'h05);
    send_req(0, 64'h1F00, 512, 32'h0000_0105, 16'h0012, 1'b1, 1'b0);
    step(40);
    n_vec++;
    if (cmd_q.size() != 2 || xl_cnt - x0 != 1) begin
      n_fail++;
      $display("FAIL split_count: cmds=%0d xl=%0d required 2 and 1", cmd_q.size(), xl_cnt - x0);
    end
    chk_cmd("split0", 0, mk_cmd(64'h8000_0F00, 23'd256, 1'b0), 0);
    chk_cmd("split1", 1, mk_cmd(64'h8000_1000, 23'd256, 1'b1), 0);
  endtask

  task automatic test_context();
    int x0 = xl_cnt;
    clear_q();
    set_resp(64'h9000_0000, 64'h4000, 48'd4096, 4'b0010, 32'h22);
    for (int p = 0; p < 3; p++) begin
      send_req(1, 64'h4000 + 64'(p * 1024), 1024, 32'h0000_0322, 16'h0021, (p == 2), 1'b0);
      step(30);
    end
    n_vec++;
    if (xl_cnt - x0 != 1 || cmd_q.size() != 3) begin
      n_fail++;
      $display("FAIL ctx_count: xl=%0d cmds=%0d required 1 and 3", xl_cnt - x0, cmd_q.size());
    end
    chk_cmd("ctx0", 0, mk_cmd(64'h9000_0000, 23'd1024, 1'b1), 1);
    chk_cmd("ctx1", 1, mk_cmd(64'h9000_0400, 23'd1024, 1'b1), 1);
    chk_cmd("ctx2", 2, mk_cmd(64'h9000_0800, 23'd1024, 1'b1), 1);
  endtask

  task automatic test_errors();
    clear_q();
    for (int c = 0; c < NCH; c++) err_cyc[c] = 0;
    set_resp(64'h8000_0000, 64'h1000, 48'd4096, 4'b0010, 32'h105);
    send_req(0, 64'h1000, 64, 32'h0000_0105, 16'h0013, 1'b1, 1'b0);
    step(30);
    n_vec++;
    if (err_cyc[0] != 1 || err_cyc[1] != 0 || cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_rkey: err0_cycles=%0d err1_cycles=%0d cmds=%0d required 1,0,0",
               err_cyc[0], err_cyc[1], cmd_q.size());
    end
    set_resp(64'h9000_0000, 64'h4000, 48'd4096, 4'b0010, 32'h22);
    send_req(1, 64'h4000, 8192, 32'h0000_0322, 16'h0022, 1'b1, 1'b0);
    step(30);
    n_vec++;
    if (err_cyc[1] != 1 || err_cyc[0] != 1 || cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_bounds: err0_cycles=%0d err1_cycles=%0d cmds=%0d required 1,1,0",
               err_cyc[0], err_cyc[1], cmd_q.size());
    end
    $display("error pulses: ch0=%0d ch1=%0d", err_cyc[0], err_cyc[1]);
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    logic [103:0] exp0 = mk_cmd(64'h2000, 23'd128, 1'b1);
    int exp_g[4] = '{0, 1, 0, 1};
    clear_q();
    step(1);
    cmd_ready_i = 1'b0;
    set_ch(0, 64'h2000, 128, 32'h0, 16'h0031, 1'b1, 1'b1);
    set_ch(1, 64'h3000, 128, 32'h0, 16'h0032, 1'b1, 1'b1);
    req_valid_i = 2'b11;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (cmd_valid_o) seen = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      n_vec++;
      if (!seen || cmd_valid_o !== 1'b1 || cmd_data_o !== exp0 || cmd_chan_o !== 1'b0 || req_ready_o !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b cmd=%h chan=%0d ready=%b required valid=1 cmd=%h chan=0 ready=00",
                 k, cmd_valid_o, cmd_data_o, cmd_chan_o, req_ready_o, exp0);
      end
    end
    step(1);
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 200 && gnt_q.size() < 4; i++) step(1);
    req_valid_i = 2'b00;
    step(40);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (gnt_q.size() <= k || gnt_q[k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got=%0d required=%0d", k, (gnt_q.size() > k) ? gnt_q[k] : -1, exp_g[k]);
      end else begin
        $display("grant %0d -> ch%0d", k, gnt_q[k]);
      end
    end
    chk_cmd("rr1", 1, mk_cmd(64'h3000, 23'd128, 1'b1), 1);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int x0;
    clear_q();
    set_resp(64'h9000_0000, 64'h4000, 48'd4096, 4'b0010, 32'h22);
    send_req(1, 64'h4000, 256, 32'h0000_0322, 16'h0041, 1'b0, 1'b0);
    step(30);
    cmd_ready_i = 1'b0;
    set_ch(0, 64'h5000, 64, 32'h0, 16'h0042, 1'b1, 1'b1);
    req_valid_i[0] = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (cmd_valid_o) seen = 1'b1;
    end
    step(1);
    req_valid_i = '0;
    aresetn_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (!seen || {cmd_valid_o, cmd_data_o, cmd_chan_o, err_o, xl_req_valid_o, xl_resp_ready_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: seen_send=%0d valid=%b cmd=%h err=%b required send seen and all 0",
               seen, cmd_valid_o, cmd_data_o, err_o);
    end
    step(3);
    aresetn_i = 1'b1;
    cmd_ready_i = 1'b1;
    step(2);
    clear_q();
    x0 = xl_cnt;
    send_req(1, 64'h4200, 256, 32'h0000_0322, 16'h0043, 1'b1, 1'b0);
    step(30);
    n_vec++;
    if (xl_cnt - x0 != 1 || cmd_q.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_fresh: xl=%0d cmds=%0d required 1 and 1", xl_cnt - x0, cmd_q.size());
    end
    chk_cmd("midreset", 0, mk_cmd(64'h9000_0200, 23'd256, 1'b1), 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_context();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
